serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk_in, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst_in, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port start_in, input, 1 bit: request a new addition.
REQ-006 SHALL have port a_in, input, WIDTH bits: operand A, sampled on accept.
REQ-007 SHALL have port b_in, input, WIDTH bits: operand B, sampled on accept.
REQ-008 SHALL have port c_in, input, 1 bit: carry-in, sampled on accept.
REQ-009 SHALL have port busy_out, output, 1 bit: high while an addition is in progress.
REQ-010 SHALL have port done_out, output, 1 bit: one-cycle result-valid pulse.
REQ-011 SHALL have port sum_out, output, WIDTH bits: registered result.
REQ-012 SHALL have port c_out, output, 1 bit: registered final carry.

Function
REQ-013 SHALL implement a three-state machine with states IDLE, SHIFT and DONE.
REQ-014 SHALL accept start_in only in IDLE: on accept, load A, B and c_in into internal registers, clear the bit counter, and move to SHIFT.
REQ-015 SHALL ignore start_in in SHIFT and DONE; operand registers and inputs are unaffected.
REQ-016 SHALL, on each SHIFT cycle:
  - add bit 0 of A, bit 0 of B and the carry register with one full_adder instance;
  - shift the sum bit into the MSB of the internal partial-sum register;
  - shift A and B right by one;
  - load the carry register from the adder carry-out;
  - increment the counter.
REQ-017 SHALL leave SHIFT for DONE after exactly WIDTH SHIFT cycles; the counter SHALL never wrap.
REQ-018 SHALL, on entering DONE, copy the partial sum to sum_out and the carry register to c_out.
REQ-019 SHALL assert done_out for exactly the single DONE cycle, then return to IDLE unconditionally.
REQ-020 SHALL meet a latency of WIDTH+1: start accepted at edge t gives done_out high in the cycle after edge t+WIDTH+1.
REQ-021 SHALL hold sum_out and c_out stable from DONE until the next DONE; intermediate sums SHALL never appear on outputs.
REQ-022 SHALL drive busy_out high in SHIFT and low in IDLE and DONE.
REQ-023 SHALL produce the arithmetic result {c_out, sum_out} = A + B + c_in, unsigned, modulo 2^(WIDTH+1).

Reset
REQ-024 SHALL, when rst_in is high at a clock edge, go to IDLE and clear sum_out, c_out, done_out, busy_out, the counter and all internal registers to 0.
REQ-025 SHALL abort an in-progress addition on reset with no done_out pulse; rst_in has priority over start_in.

Configuration
REQ-026 SHALL, with SERIAL_ADDER_OVF_EN defined, add port ovf_out (output, 1 bit): two's-complement overflow of the result.
REQ-027 SHALL register ovf_out on entering DONE as (A[MSB]==B[MSB]) and (sum[MSB]!=A[MSB]), using the operands as sampled at accept; reset value 0.
REQ-028 SHALL, without SERIAL_ADDER_OVF_EN, have no ovf_out port and no related logic, with all other behaviour identical.

Structure
REQ-029 SHALL take state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default width constant from shared package serial_adder_pkg.
REQ-030 SHALL reuse the existing full_adder module as its single sub-module; no other sub-modules.

Verification
REQ-031 SHALL be verified (WIDTH=8) with the following directed scenarios:
  - A=0x0F, B=0x01, c_in=0 -> sum_out=0x10, c_out=0, done_out high exactly 9 edges after accept.
  - A=0xFF, B=0x01, c_in=0 -> sum_out=0x00, c_out=1 (ovf_out=0 if enabled).
  - A=0x7F, B=0x01, c_in=0 -> sum_out=0x80, c_out=0, ovf_out=1 if enabled.
  - A=0xFF, B=0x00, c_in=1 -> sum_out=0x00, c_out=1.
  - start_in pulsed in SHIFT with new operands -> ignored, first result unchanged, one done_out only.
  - rst_in high in the 4th SHIFT cycle -> IDLE next cycle, all outputs 0, no done_out; next start completes normally.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module : serial_adder_pkg
// Brief  : Shared state encoding and default width for the serial adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module : full_adder
// Brief  : One-bit full adder used as the serial adder's bit-slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic c_out
);

  assign sum_out = a_in ^ b_in ^ c_in;
  assign c_out   = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module : serial_adder
// Brief  : Bit-serial unsigned adder, LSB first, one bit per clock.
//          Optional two's-complement overflow output: define SERIAL_ADDER_OVF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf_out,
`endif
  output logic             c_out
);

  // One extra counter bit so the final increment to WIDTH never wraps.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] psum_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a_in    (a_q[0]),
    .b_in    (b_q[0]),
    .c_in    (carry_q),
    .sum_out (fa_sum),
    .c_out   (fa_cout)
  );

  assign psum_d = {fa_sum, psum_q[WIDTH-1:1]};

`ifdef SERIAL_ADDER_OVF_EN
  // Operand sign bits are captured at accept since a_q/b_q shift away.
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= c_in;
            psum_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= a_in[WIDTH-1];
            b_msb_q <= b_in[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          psum_q  <= psum_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          sum_q   <= psum_q;
          cout_q  <= carry_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_q   <= (a_msb_q == b_msb_q) && (psum_q[WIDTH-1] != a_msb_q);
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign sum_out  = sum_q;
  assign c_out    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_out  = ovf_q;
`endif

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module : tb_serial_adder
// Brief  : Directed self-checking bench for serial_adder (WIDTH=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         start_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] sum_out;
  logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] last_sum = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (start_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
    .busy_out (busy_out),
    .done_out (done_out),
    .sum_out  (sum_out),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf_out  (ovf_out),
`endif
    .c_out    (c_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // Launch one addition and verify latency, result, single-pulse done and hold.
  task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] exp_sum, input logic exp_c,
                        input logic exp_ovf);
    int edges;
    @(negedge clk_in);
    a_in = a; b_in = b; c_in = ci; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check({tag, " busy"}, 32'(busy_out), 32'd1);
    check({tag, " sum held"}, 32'(sum_out), 32'(last_sum));
    edges = 0;
    while (!done_out && edges < 40) begin
      @(posedge clk_in); #1;
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'd9);
    check({tag, " sum"}, 32'(sum_out), 32'(exp_sum));
    check({tag, " cout"}, 32'(c_out), 32'(exp_c));
    check({tag, " busy@done"}, 32'(busy_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, " ovf"}, 32'(ovf_out), 32'(exp_ovf));
`else
    if (exp_ovf !== exp_ovf) $display("unreachable");
`endif
    @(posedge clk_in); #1;
    check({tag, " done pulse"}, 32'(done_out), 32'd0);
    check({tag, " hold"}, 32'({c_out, sum_out}), 32'({exp_c, exp_sum}));
    last_sum = exp_sum;
  endtask

  initial begin
    int dones;
    rst_in = 1'b1; start_in = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    check("rst sum",  32'(sum_out),  32'd0);
    check("rst cout", 32'(c_out),    32'd0);
    check("rst busy", 32'(busy_out), 32'd0);
    check("rst done", 32'(done_out), 32'd0);

    do_add("0F+01",   8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    do_add("FF+01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add("7F+01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add("FF+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    do_add("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_add("80+80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_add("5A+25+1", 8'h5A, 8'h25, 1'b1, 8'h80, 1'b0, 1'b1);

    // start pulsed mid-SHIFT with new operands must be ignored
    @(negedge clk_in);
    a_in = 8'h0F; b_in = 8'h01; c_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    a_in = 8'hAA; b_in = 8'h55; c_in = 1'b1; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); #1;
      if (done_out) begin
        dones++;
        check("ign sum",  32'(sum_out), 32'h10);
        check("ign cout", 32'(c_out),   32'd0);
      end
    end
    check("ign dones", 32'(dones), 32'd1);
    last_sum = 8'h10;

    // reset during the 4th SHIFT cycle aborts with no done pulse
    @(negedge clk_in);
    a_in = 8'h33; b_in = 8'h44; c_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in); rst_in = 1'b1;
    @(posedge clk_in); #1;
    check("abort busy", 32'(busy_out), 32'd0);
    check("abort done", 32'(done_out), 32'd0);
    check("abort sum",  32'(sum_out),  32'd0);
    check("abort cout", 32'(c_out),    32'd0);
    @(negedge clk_in); rst_in = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_in); #1;
      if (done_out) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    last_sum = '0;
    do_add("post-rst", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_adder

`default_nettype wire
